fp_mult_arbiter: RTL and testbench
==================================

// Module: fp_mult_arbiter
// PURPOSE
// - Shares one pipelined FPmult (IEEE-754 single) among N_REQ requesters.
// - Round-robin, one grant per cycle, valid/ready on the request side.
// - Tracks the requester ID through the multiplier pipe.
// - Returns each result one-hot to its requester.
// - Sits between compute clients and the single FPmult instance, which it
//   instantiates internally.
// PARAMETERS
// - N_REQ     4  number of requesters, 2..16
// - MULT_LAT  1  FPmult latency in cycles, from operand edge to result_reg valid
// - IDW       localparam = $clog2(N_REQ); width of the requester ID
// PORTS
// - clk         in   1           single clock, rising edge
// - rst         in   1           asynchronous, active-low reset
// - hold        in   1           1 = issue no new grants; in-flight ops still complete
// - req_valid   in   N_REQ       per-requester operation valid
// - req_ready   out  N_REQ       one-hot grant; transfer = req_valid[i] & req_ready[i]
// - req_a       in   N_REQ*32    operand A, requester i at [32*i+31:32*i]
// - req_b       in   N_REQ*32    operand B, same packing as req_a
// - rsp_valid   out  N_REQ       one-hot result strobe, one cycle per accepted op
// - rsp_result  out  32          product for the strobed requester
// - rsp_id      out  IDW         index of the strobed requester
// - busy        out  1           1 while any op is in flight
// BEHAVIOUR
// - Reset (rst=0, async): all outputs go to 0, the RR pointer goes to 0, and
//   every tag/valid pipe stage is cleared.
//   - FPmult's rst is driven with ~rst.
//   - Ops in flight at reset are dropped and never produce rsp_valid.
// - Arbitration (combinational):
//   - grant = first i with req_valid[i]=1, searching from ptr upward, wrapping
//     N_REQ-1 -> 0.
//   - req_ready = onehot(grant) when hold=0 and any req_valid=1; otherwise 0.
//   - req_ready never depends on req_a or req_b.
// - Pointer: on a transfer, ptr <= grant+1 mod N_REQ. With no transfer, ptr holds.
// - Issue: on a transfer edge, the selected operands are registered into the
//   FPmult m/q input regs, and {1'b1, grant} enters tag stage 0.
//   - With no transfer, tag stage 0 gets valid=0, and m/q hold their previous
//     values.
// - Tag pipe: MULT_LAT+1 stages, advancing every cycle. There is no stall and no
//   backpressure on results.
// - Latency: rsp_valid[id] is high in the cycle starting MULT_LAT+1 edges after
//   the accepting edge. For default parameters, an op accepted at edge k responds
//   after edge k+2.
//   - rsp_result and rsp_id are valid only while rsp_valid != 0.
//   - When rsp_valid = 0, rsp_result and rsp_id hold their last value.
// - Throughput: 1 op per cycle. Back-to-back grants to the same requester are
//   allowed only if it is the sole requester.
// - Ordering: responses come back in grant order, and each accepted op returns
//   exactly one response.
// - Simultaneous events:
//   - A new grant and a response in the same cycle are independent.
//   - hold rising mid-stream blocks only new grants.
//   - Requesters may drop req_valid without a transfer.
// - busy = OR of all tag-stage valids, registered with the stages.
// - Arithmetic: the product is exactly FPmult's output. Sign, exponent and
//   mantissa are not modified; zero operands give 0x00000000.
// CONFIGURATION
// - FPMA_STATS_EN defined: adds outputs stat_ops[31:0] and stat_conflict[31:0].
//   - stat_ops counts transfers.
//   - stat_conflict counts cycles with hold=0 and >=2 req_valid bits set.
//   - Both reset to 0, wrap modulo 2^32, and are updated at the clock edge.
// - FPMA_STATS_EN undefined: these ports and counters do not exist. All other
//   behaviour is identical.
// TESTING
// - Single op, N_REQ=4:
//   - Stimulus: req 2 sends 0x43E44461 * 0x458DC608.
//   - Required: req_ready=4'b0100 the same cycle; 2 cycles later
//     rsp_valid=4'b0100, rsp_id=2, rsp_result=0x49FCD47A.
// - All 4 requesters valid continuously, each sending 0x3F800000 * 0xC3E44461:
//   - grants go 0,1,2,3,0,... on consecutive cycles;
//   - every response is 0xC3E44461 with rsp_id following the same order.
// - Sign and zero cases:
//   - 0x43E44461 * 0xC58DC608 -> 0xC9FCD47A;
//   - 0xC3E44461 * 0xC58DC608 -> 0x49FCD47A;
//   - 0xC3E44461 * 0x00000000 -> 0x00000000.
// - hold=1 with req_valid=4'b1111: req_ready stays 0; ops already in flight still
//   respond; releasing hold resumes grants from the saved ptr.
// - Async reset asserted one cycle after a grant: outputs go to 0 immediately; no
//   rsp_valid for that op after release; the first grant after reset goes to
//   requester 0.
// - FPMA_STATS_EN: 10 transfers with 3 two-requester conflict cycles ->
//   stat_ops=10, stat_conflict=3.

Source files
------------

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one pipelined single-precision multiplier among
// N_REQ requesters. Round-robin grant (one per cycle), requester ID carried
// through a tag pipe alongside the multiplier, one-hot response strobe.
// Optional statistics outputs are enabled by defining FPMA_STATS_EN.
// fp_mult (below) is the shared multiplier: truncating IEEE-754 single
// multiply, subnormals flushed to +0, registered operands and result.

module fp_mult_arbiter #(
  parameter int N_REQ    = 4,   // 2..16
  parameter int MULT_LAT = 1,   // >= 1
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_result,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy
`ifdef FPMA_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_conflict
`endif
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_next;
  logic           found;
  logic           transfer;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [31:0]    mult_result;
  logic           mult_rst;

  logic           tag_valid [MULT_LAT+1];
  logic [IDW-1:0] tag_id    [MULT_LAT+1];
  logic           in_flight;

  function automatic int wrap_idx(input int i);
    return (i >= N_REQ) ? i - N_REQ : i;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latch).
    grant = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!found && req_valid[wrap_idx(int'(ptr) + off)]) begin
        found = 1'b1;
        grant = IDW'(wrap_idx(int'(ptr) + off));
      end
    end
  end

  // A grant is only offered out of reset, not on hold, with someone asking;
  // the search then always lands on a valid requester, so offer == transfer.
  assign transfer  = rst && !hold && found;
  assign req_ready = transfer ? onehot(grant) : '0;
  assign ptr_next  = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
  assign sel_a     = req_a[32*grant +: 32];
  assign sel_b     = req_b[32*grant +: 32];
  assign mult_rst  = ~rst;

  // Pointer and ID tag pipe; the tag pipe runs in lockstep with the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      // NOTE: tag stages are reset, not just their data, so ops in flight
      // at reset are dropped and never raise rsp_valid.
      for (int i = 0; i <= MULT_LAT; i++) begin
        tag_valid[i] <= 1'b0;
        tag_id[i]    <= '0;
      end
      busy <= 1'b0;
    end else begin
      if (transfer) ptr <= ptr_next;
      tag_valid[0] <= transfer;
      tag_id[0]    <= grant;
      for (int i = 1; i <= MULT_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      busy <= transfer | in_flight;
    end
  end

  // Stages 0..MULT_LAT-1 are the ones that stay in the pipe after this edge.
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < MULT_LAT; i++) in_flight = in_flight | tag_valid[i];
  end

  // Response register: strobe one-hot, data holds when nothing returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      rsp_valid <= tag_valid[MULT_LAT] ? onehot(tag_id[MULT_LAT]) : '0;
      if (tag_valid[MULT_LAT]) begin
        rsp_result <= mult_result;
        rsp_id     <= tag_id[MULT_LAT];
      end
    end
  end

  fp_mult #(.LAT(MULT_LAT)) u_fp_mult (
    .clk    (clk),
    .rst    (mult_rst),
    .load   (transfer),
    .a      (sel_a),
    .b      (sel_b),
    .result (mult_result)
  );

`ifdef FPMA_STATS_EN
  int n_valid;

  // Count of requesters asking this cycle, for conflict statistics.
  always_comb begin
    n_valid = 0;
    for (int i = 0; i < N_REQ; i++) n_valid = n_valid + int'(req_valid[i]);
  end

  // Transfer and conflict counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops      <= '0;
      stat_conflict <= '0;
    end else begin
      if (transfer) stat_ops <= stat_ops + 32'd1;
      if (!hold && n_valid >= 2) stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// Shared multiplier: operand regs m/q load on 'load', result appears LAT
// edges after the operand edge. Active-high asynchronous reset.
module fp_mult #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0] m;
  logic [31:0] q;
  logic [31:0] prod;
  logic [31:0] stage [LAT];

  // Truncating single multiply. NaN in, or inf*0, gives the canonical NaN;
  // zero/subnormal operands and underflow give +0; overflow gives +-inf.
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic              sgn;
    logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       frac;
    sgn    = x[31] ^ y[31];
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == '0);
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != '0);
    p      = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e      = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]})
           + $signed({9'd0, p[47]}) - 10'sd127;
    frac   = p[47] ? p[46:24] : p[45:23];
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
      return 32'h7FC0_0000;
    else if (x_inf || y_inf)
      return {sgn, 8'hFF, 23'd0};
    else if (x_zero || y_zero)
      return 32'h0000_0000;
    else if (e >= 10'sd255)
      return {sgn, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      return 32'h0000_0000;
    else
      return {sgn, e[7:0], frac};
  endfunction

  // Operand registers hold between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
      q <= '0;
    end else if (load) begin
      m <= a;
      q <= b;
    end
  end

  // Combinational product of the registered operands.
  always_comb prod = fmul(m, q);

  // Result pipe; the last stage is the result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= prod;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign result = stage[LAT-1];

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: directed cases plus randomized
// traffic against a transaction-level model (round-robin pointer, response
// queue with due cycle, arithmetic multiply reference).
module tb_fp_mult_arbiter;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           hold;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [31:0]    rsp_result;
  logic [1:0]     rsp_id;
  logic           busy;
`ifdef FPMA_STATS_EN
  logic [31:0]    stat_ops;
  logic [31:0]    stat_conflict;
`endif

  always #5 clk = ~clk;

  fp_mult_arbiter #(.N_REQ(N), .MULT_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef FPMA_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_conflict (stat_conflict)
`endif
  );

  typedef struct {
    int          due;
    int          id;
    logic [31:0] res;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          m_ptr   = 0;
  logic [31:0] m_last_res = '0;
  int          m_last_id  = 0;
  logic [31:0] m_ops  = '0;
  logic [31:0] m_conf = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference multiply from the number's value: product of the integer
  // significands, renormalised by shifting, truncated to 24 bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int              ea, eb, s, e;
    bit              sg, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned prod;
    sg     = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return 32'h7FC00000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
    if (a_inf || b_inf) return {sg, 8'hFF, 23'd0};
    if (a_zero || b_zero) return 32'h00000000;
    prod = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    s = 0;
    while (prod >= 64'd16777216) begin
      prod = prod >> 1;
      s++;
    end
    e = ea + eb - 150 + s;
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0) return 32'h00000000;
    return {sg, 8'(e), prod[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int          k;
    logic [31:0] r;
    k = $urandom_range(0, 19);
    r = $urandom;
    case (k)
      0: r = 32'h0;
      1: r = {r[31], 8'hFF, 23'd0};
      2: r = {r[31], 8'hFF, 1'b1, r[21:0]};
      3: r[30:23] = 8'h00;
      4: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(90, 165));
    endcase
    return r;
  endfunction

  function automatic int model_grant();
    if (!rst || hold) return -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // One clock: check the offered grant mid-cycle, advance the model at the
  // edge, check registered outputs just after it.
  task automatic cycle();
    int          g;
    int          nv;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_valid;
    rsp_t        r;
    @(negedge clk);
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    nv = $countones(req_valid);
    @(posedge clk);
    cyc++;
    if (rst) begin
      if (g >= 0) begin
        exp_q.push_back('{due: cyc + LAT + 1, id: g,
                          res: ref_mul(req_a[32*g +: 32], req_b[32*g +: 32])});
        m_ptr = (g + 1) % N;
        m_ops = m_ops + 32'd1;
      end
      if (!hold && nv >= 2) m_conf = m_conf + 32'd1;
    end
    #1;
    exp_valid = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_valid[r.id] = 1'b1;
      m_last_res = r.res;
      m_last_id  = r.id;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check("rsp_id", 32'(rsp_id), 32'(m_last_id));
    check("rsp_result", rsp_result, m_last_res);
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
`ifdef FPMA_STATS_EN
    check("stat_ops", stat_ops, m_ops);
    check("stat_conflict", stat_conflict, m_conf);
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_last_res = '0;
    m_last_id  = 0;
    m_ops      = '0;
    m_conf     = '0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_result"}, rsp_result, 32'h0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
  endtask

  task automatic single_op(input string tag, input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_valid = oh;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(oh));
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check({tag, "_strobe"}, 32'(rsp_valid), 32'(oh));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_result"}, rsp_result, exp_res);
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    #1;
    async_reset("por");
    repeat (2) cycle();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle();

    // Directed arithmetic cases, including the sign and zero rules.
    single_op("single", 2, 32'h43E44461, 32'h458DC608, 32'h49FCD47A);
    single_op("neg_b",  1, 32'h43E44461, 32'hC58DC608, 32'hC9FCD47A);
    single_op("neg_ab", 3, 32'hC3E44461, 32'hC58DC608, 32'h49FCD47A);
    single_op("zero",   0, 32'hC3E44461, 32'h00000000, 32'h00000000);

    // Everyone valid: grants rotate one per cycle, results are exact copies.
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h3F800000;
      req_b[32*i +: 32] = 32'hC3E44461;
    end
    req_valid = '1;
    repeat (12) cycle();
    check("rr_result", rsp_result, 32'hC3E44461);

    // hold blocks new grants only; in-flight ops still return.
    hold = 1'b1;
    repeat (4) cycle();
    check("hold_ready", 32'(req_ready), 32'h0);
    hold = 1'b0;
    repeat (4) cycle();
    req_valid = '0;
    repeat (3) cycle();

    // Randomized traffic: valids, hold and operands change every cycle.
    for (int n = 0; n < 500; n++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      hold      = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = rand_fp();
        req_b[32*i +: 32] = rand_fp();
      end
      cycle();
    end
    hold      = 1'b0;
    req_valid = '0;
    repeat (3) cycle();

    // Reset one cycle after a grant: the op is dropped, ptr restarts at 0.
    req_valid = 4'b0100;
    req_a[95:64] = 32'h43E44461;
    req_b[95:64] = 32'h458DC608;
    cycle();
    req_valid = 4'b1111;
    hold = 1'b1;
    cycle();
    #1;
    async_reset("mid");
    hold = 1'b0;
    repeat (3) cycle();
    #1;
    rst = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    repeat (3) cycle();

`ifdef FPMA_STATS_EN
    // Ten transfers, three of them in two-requester conflict cycles.
    #1;
    async_reset("stats");
    #1;
    rst = 1'b1;
    req_valid = 4'b0011;
    repeat (3) cycle();
    req_valid = 4'b0001;
    repeat (7) cycle();
    req_valid = '0;
    cycle();
    check("stat_ops_10", stat_ops, 32'd10);
    check("stat_conflict_3", stat_conflict, 32'd3);
    repeat (3) cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
